// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (S1 operand register, S2 result/flag register).
// Optional sticky overflow/carry flags are built when ALU_STICKY_FLAGS_EN is defined.
module alu_pipe #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    input  logic                  flag_clr,
    output logic                  sticky_ovf,
    output logic                  sticky_carry
);
    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpNor  = 3'b100;
    localparam logic [2:0] OpSltu = 3'b101;
    localparam logic [2:0] OpSub  = 3'b110;
    localparam logic [2:0] OpSlt  = 3'b111;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  ovf_q, ovf_d, carry_q, carry_d, zero_q, zero_d;

    logic                  s1_adv, accept;
    logic                  is_sub, carry_msb, add_ovf, arith_cout;
    logic [DATA_WIDTH-1:0] b_eff, alu_res;
    logic [DATA_WIDTH:0]   sum;
    logic                  alu_ovf, alu_carry;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || s1_adv);
    assign accept   = in_valid && in_ready;

    // Shared adder: subtract-type ops use A + ~B + 1, so carry-out of 0 means borrow.
    always_comb begin
        is_sub     = (op_q == OpSub) || (op_q == OpSlt) || (op_q == OpSltu);
        b_eff      = is_sub ? ~b_q : b_q;
        sum        = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};
        carry_msb  = a_q[DATA_WIDTH-1] ^ b_eff[DATA_WIDTH-1] ^ sum[DATA_WIDTH-1];
        add_ovf    = carry_msb ^ sum[DATA_WIDTH];
        arith_cout = sum[DATA_WIDTH] ^ is_sub;
        alu_res    = '0;
        alu_ovf    = 1'b0;
        alu_carry  = 1'b0;
        case (op_q)
            OpAnd:  alu_res = a_q & b_q;
            OpOr:   alu_res = a_q | b_q;
            OpXor:  alu_res = a_q ^ b_q;
            OpNor:  alu_res = ~(a_q | b_q);
            OpAdd, OpSub: begin
                alu_res   = sum[DATA_WIDTH-1:0];
                alu_ovf   = add_ovf;
                alu_carry = arith_cout;
            end
            OpSlt: begin
                alu_res   = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ add_ovf};
                alu_ovf   = add_ovf;
                alu_carry = arith_cout;
            end
            OpSltu: begin
                alu_res   = {{(DATA_WIDTH-1){1'b0}}, arith_cout};
                alu_carry = arith_cout;
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = A;
            b_d        = B;
            op_d       = ALUop;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Result and flags are forced to zero whenever S2 holds nothing.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            result_d   = s1_valid_q ? alu_res : '0;
            ovf_d      = s1_valid_q && alu_ovf;
            carry_d    = s1_valid_q && alu_carry;
            zero_d     = s1_valid_q && (alu_res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = carry_q;
    assign Zero      = zero_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic sticky_ovf_q, sticky_ovf_d, sticky_carry_q, sticky_carry_d;
    logic out_hs;

    // A setting handshake wins over a simultaneous clear.
    always_comb begin
        out_hs         = s2_valid_q && out_ready;
        sticky_ovf_d   = (out_hs && ovf_q) || (sticky_ovf_q && !flag_clr);
        sticky_carry_d = (out_hs && carry_q) || (sticky_carry_q && !flag_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
        end else begin
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
        end
    end

    assign sticky_ovf   = sticky_ovf_q;
    assign sticky_carry = sticky_carry_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign sticky_ovf      = 1'b0;
    assign sticky_carry    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed bench for alu_pipe against a queue-based arithmetic model.
// Sticky-flag expectations follow ALU_STICKY_FLAGS_EN, as in the design.
module tb_alu_pipe;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic [2:0]   ALUop;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] Result;
    logic         Overflow, CarryOut, Zero;
    logic         flag_clr, sticky_ovf, sticky_carry;

    alu_pipe #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALUop(ALUop),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero),
        .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         cout;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t forced;
    logic force_exp = 1'b0;
    logic st_ovf_m = 1'b0, st_carry_m = 1'b0;
    logic ir_s, ov_s;
    int   total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Arithmetic reference: signed/unsigned values widened to 64 bits.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sb, s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b011: e.res = a ^ b;
            3'b100: e.res = ~(a | b);
            3'b010: begin
                e.res  = a + b;
                e.cout = (ua + ub) >= 64'sd4294967296;
                s      = sa + sb;
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                e.res  = a - b;
                e.cout = ua < ub;
                s      = sa - sb;
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111: begin
                e.res  = (sa < sb) ? 1 : 0;
                e.cout = ua < ub;
                s      = sa - sb;
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: begin
                e.res  = (ua < ub) ? 1 : 0;
                e.cout = ua < ub;
            end
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic cycle(input logic r, input logic iv, input logic [2:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, input logic clr);
        exp_t e;
        logic hs, acc;
        @(negedge clk);
        rst = r; in_valid = iv; ALUop = o; A = a; B = b; out_ready = ordy; flag_clr = clr;
        #1;
        ir_s = in_ready;
        ov_s = out_valid;
        hs   = 1'b0;
        e    = '0;
        if (r) begin
            check("rst_in_ready", in_ready, 0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("result", Result, e.res);
                    check("overflow", Overflow, e.ovf);
                    check("carryout", CarryOut, e.cout);
                    check("zero", Zero, e.zero);
                    hs = out_ready;
                end
            end else begin
                check("idle_outputs", {Result, Overflow, CarryOut, Zero}, 0);
            end
            check("sticky_ovf", sticky_ovf, st_ovf_m);
            check("sticky_carry", sticky_carry, st_carry_m);
        end
        acc = iv && in_ready && !r;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            st_ovf_m   = 1'b0;
            st_carry_m = 1'b0;
        end else begin
            if (hs) void'(exp_q.pop_front());
`ifdef ALU_STICKY_FLAGS_EN
            st_ovf_m   = (hs && e.ovf) || (st_ovf_m && !clr);
            st_carry_m = (hs && e.cout) || (st_carry_m && !clr);
`endif
            if (acc) exp_q.push_back(force_exp ? forced : ref_model(o, a, b));
        end
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'b000, '0, '0, 1'b1, clr);
    endtask

    task automatic dir_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic ovf, input logic cout,
                          input logic zero, input logic clr);
        force_exp = 1'b1;
        forced    = {res, ovf, cout, zero};
        cycle(1'b0, 1'b1, o, a, b, 1'b1, clr);
        force_exp = 1'b0;
        check("dir_accept", ir_s, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; ALUop = '0; A = '0; B = '0;
        out_ready = 1'b0; flag_clr = 1'b0;

        cycle(1'b1, 1'b1, 3'b010, 1, 1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 3'b010, 1, 1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 0, 0, 1'b1, 1'b0);
        check("rst_release_ready", ir_s, 1);
        check("rst_out_valid", ov_s, 0);

        // Corner results and two-cycle latency
        dir_op(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0, 0);
        cycle(1'b0, 1'b0, 3'b000, 0, 0, 1'b1, 1'b0);
        check("latency_k1", ov_s, 0);
        cycle(1'b0, 1'b0, 3'b000, 0, 0, 1'b1, 1'b0);
        check("latency_k2", ov_s, 1);
        dir_op(3'b110, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1, 0, 0);
        dir_op(3'b110, 32'h5, 32'h5, 32'h0, 0, 0, 1, 0);
        dir_op(3'b111, 32'h8000_0000, 32'h1, 32'h1, 1, 0, 0, 0);
        dir_op(3'b101, 32'h8000_0000, 32'h1, 32'h0, 0, 0, 1, 0);
        dir_op(3'b100, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        idle(4, 1'b1);
        check("directed_drained", exp_q.size(), 0);

        // Backpressure: two accepted, third blocked, outputs frozen, then in-order release
        cycle(1'b0, 1'b1, 3'b010, 32'd10, 32'd20, 1'b0, 1'b0);
        check("bp_first_ready", ir_s, 1);
        cycle(1'b0, 1'b1, 3'b011, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
        check("bp_second_ready", ir_s, 1);
        cycle(1'b0, 1'b1, 3'b110, 32'd3, 32'd9, 1'b0, 1'b0);
        check("bp_third_blocked", ir_s, 0);
        check("bp_out_valid", ov_s, 1);
        cycle(1'b0, 1'b1, 3'b110, 32'd3, 32'd9, 1'b0, 1'b0);
        check("bp_still_blocked", ir_s, 0);
        check("bp_out_held", ov_s, 1);
        cycle(1'b0, 1'b1, 3'b110, 32'd3, 32'd9, 1'b1, 1'b0);
        check("bp_third_accepted", ir_s, 1);
        idle(4, 1'b0);
        check("bp_drained", exp_q.size(), 0);

        // Reset with two operations in flight
        cycle(1'b0, 1'b1, 3'b010, 32'd1, 32'd2, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b010, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 0, 0, 1'b1, 1'b0);
        check("midrst_out_valid", ov_s, 0);
        check("midrst_in_ready", ir_s, 1);
        idle(4, 1'b0);

`ifdef ALU_STICKY_FLAGS_EN
        dir_op(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0, 0);
        idle(3, 1'b0);
        #1 check("sticky_set", sticky_ovf, 1);
        dir_op(3'b010, 32'h1, 32'h1, 32'h2, 0, 0, 0, 0);
        idle(3, 1'b0);
        #1 check("sticky_persist", sticky_ovf, 1);
        idle(1, 1'b1);
        #1 check("sticky_cleared", sticky_ovf, 0);
        dir_op(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0, 0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        #1 check("sticky_set_wins", sticky_ovf, 1);
        dir_op(3'b110, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1, 0, 1);
        idle(1, 1'b1);
        idle(1, 1'b1);
        #1 check("sticky_carry_set_wins", sticky_carry, 1);
        idle(2, 1'b1);
`endif

        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), pick(), pick(),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
        end
        idle(10, 1'b0);
        check("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
